// File: rtl/stepper_onehot_seq_if.sv
// Control and phase-line bundle for the one-hot stepper sequencer.
// The master drives the controls; the slave (sequencer) drives the registered outputs.
`timescale 1ns/1ps
interface stepper_onehot_seq_if #(
    parameter int unsigned N_STEPS = 29,
    parameter int unsigned PRESC_W = 8
);
    localparam int unsigned POS_W = $clog2(N_STEPS);

    logic               start;
    logic               stop;
    logic               en;
    logic               dir;
    logic               mode;
    logic [PRESC_W-1:0] div;
    logic [N_STEPS-1:0] step;
    logic [POS_W-1:0]   pos;
    logic               busy;
    logic               wrap;
    logic               done;

    modport master (
        output start, stop, en, dir, mode, div,
        input  step, pos, busy, wrap, done
    );

    modport slave (
        input  start, stop, en, dir, mode, div,
        output step, pos, busy, wrap, done
    );
endinterface

// File: rtl/stepper_onehot_seq.sv
// One-hot stepper sequencer: prescaled forward/reverse stepping over N_STEPS phase lines,
// continuous (wrapping) or one-shot, with start/stop/pause control and wrap/done pulses.
`timescale 1ns/1ps
module stepper_onehot_seq #(
    parameter int unsigned N_STEPS = 29,
    parameter int unsigned PRESC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stepper_onehot_seq_if.slave  bus
);
    localparam int unsigned POS_W = $clog2(N_STEPS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_STEPS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   pc_q, pc_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [N_STEPS-1:0]   step_q, step_d;
    logic                 busy_q, busy_d;
    logic                 wrap_q, wrap_d;
    logic                 done_q, done_d;

    logic [POS_W-1:0]     origin;
    logic [POS_W-1:0]     end_pos;
    logic [POS_W-1:0]     pos_adv;
    logic                 crossing;

    // Next-state, counter and position logic; stop beats start beats advance.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pos_d    = pos_q;
        wrap_d   = 1'b0;
        done_d   = 1'b0;
        origin   = bus.dir ? POS_LAST : '0;
        end_pos  = bus.dir ? '0 : POS_LAST;
        crossing = bus.dir ? (pos_q == '0) : (pos_q == POS_LAST);
        if (bus.dir) begin
            pos_adv = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        end else begin
            pos_adv = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                pc_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d = S_RUN;
                    if (bus.mode) begin
                        pos_d = origin;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end else if (bus.start && bus.mode) begin
                    pos_d = origin;
                    pc_d  = '0;
                end else if (bus.en) begin
                    if (pc_q >= bus.div) begin
                        pc_d   = '0;
                        pos_d  = pos_adv;
                        wrap_d = crossing && !bus.mode;
                        // One-shot terminates on arrival at the end position.
                        if (bus.mode && (pos_adv == end_pos)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + PRESC_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase

        step_d = N_STEPS'(1) << pos_d;
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            pos_q   <= '0;
            step_q  <= N_STEPS'(1);
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign bus.step = step_q;
    assign bus.pos  = pos_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_stepper_onehot_seq.sv
// Directed scoreboard bench for stepper_onehot_seq: a 29-step/8-bit instance and a
// 4-step/2-bit instance sharing clock and reset.
`timescale 1ns/1ps
module tb_stepper_onehot_seq;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stepper_onehot_seq_if #(.N_STEPS(29), .PRESC_W(8)) ifa ();
    stepper_onehot_seq_if #(.N_STEPS(4),  .PRESC_W(2)) ifb ();

    stepper_onehot_seq #(.N_STEPS(29), .PRESC_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    stepper_onehot_seq #(.N_STEPS(4),  .PRESC_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        bit    sel;
        string tag;
        int    p;
        bit    b;
        bit    w;
        bit    d;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic ex_a(input string tag, input int p, input bit b, input bit w, input bit d);
        exp_t e;
        e.sel = 1'b0; e.tag = tag; e.p = p; e.b = b; e.w = w; e.d = d;
        sb.push_back(e);
    endtask

    task automatic ex_b(input string tag, input int p, input bit b, input bit w, input bit d);
        exp_t e;
        e.sel = 1'b1; e.tag = tag; e.p = p; e.b = b; e.w = w; e.d = d;
        sb.push_back(e);
    endtask

    // Advance one clock, then retire every expectation queued for this edge.
    task automatic tick();
        exp_t e;
        logic [63:0] one_hot;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            one_hot = 64'(1) << e.p;
            if (!e.sel) begin
                cmp({e.tag, ".pos"},  64'(ifa.pos),  64'(e.p));
                cmp({e.tag, ".step"}, 64'(ifa.step), one_hot);
                cmp({e.tag, ".busy"}, 64'(ifa.busy), 64'(e.b));
                cmp({e.tag, ".wrap"}, 64'(ifa.wrap), 64'(e.w));
                cmp({e.tag, ".done"}, 64'(ifa.done), 64'(e.d));
            end else begin
                cmp({e.tag, ".pos"},  64'(ifb.pos),  64'(e.p));
                cmp({e.tag, ".step"}, 64'(ifb.step), one_hot);
                cmp({e.tag, ".busy"}, 64'(ifb.busy), 64'(e.b));
                cmp({e.tag, ".wrap"}, 64'(ifb.wrap), 64'(e.w));
                cmp({e.tag, ".done"}, 64'(ifb.done), 64'(e.d));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.start = 1'b1; ifa.stop = 1'b0; ifa.en = 1'b0; ifa.dir = 1'b0; ifa.mode = 1'b0; ifa.div = 8'd0;
        ifb.start = 1'b0; ifb.stop = 1'b0; ifb.en = 1'b0; ifb.dir = 1'b0; ifb.mode = 1'b0; ifb.div = 2'd0;

        // T1: two reset cycles with start held high
        tick();
        ex_a("t1_rst", 0, 0, 0, 0);
        ex_b("t1_rst_b", 0, 0, 0, 0);
        tick();
        rst = 1'b0; ifa.start = 1'b0;
        ex_a("t1_idle", 0, 0, 0, 0);
        tick();

        // T2: continuous forward, div=0
        ifa.en = 1'b1; ifa.start = 1'b1;
        ex_a("t2_go", 0, 1, 0, 0);
        tick();
        ifa.start = 1'b0;
        for (int i = 1; i <= 29; i++) begin
            ex_a($sformatf("t2_%0d", i), i % 29, 1, i == 29, 0);
            tick();
        end
        ifa.stop = 1'b1;
        ex_a("t2_stop", 0, 0, 0, 0);
        tick();
        ifa.stop = 1'b0;

        // T3: continuous reverse, div=3, from pos 0
        ifa.dir = 1'b1; ifa.div = 8'd3; ifa.start = 1'b1;
        ex_a("t3_go", 0, 1, 0, 0);
        tick();
        ifa.start = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            ex_a($sformatf("t3_%0d", t), (t < 4) ? 0 : ((t < 8) ? 28 : 27), 1, t == 4, 0);
            tick();
        end
        ifa.stop = 1'b1;
        ex_a("t3_stop", 27, 0, 0, 0);
        tick();
        ifa.stop = 1'b0;

        // Park at pos 10 using continuous forward stepping
        ifa.dir = 1'b0; ifa.div = 8'd0; ifa.start = 1'b1;
        ex_a("park_go", 27, 1, 0, 0);
        tick();
        ifa.start = 1'b0;
        repeat (12) tick();
        ifa.stop = 1'b1;
        ex_a("park_10", 10, 0, 0, 0);
        tick();
        ifa.stop = 1'b0;

        // T4: one-shot forward, div=1, reload from 10 to origin 0
        ifa.mode = 1'b1; ifa.div = 8'd1; ifa.start = 1'b1;
        ex_a("t4_go", 0, 1, 0, 0);
        tick();
        ifa.start = 1'b0;
        for (int t = 1; t <= 56; t++) begin
            ex_a($sformatf("t4_%0d", t), t / 2, t < 56, 0, t == 56);
            tick();
        end
        for (int t = 0; t < 3; t++) begin
            ex_a($sformatf("t4_hold_%0d", t), 28, 0, 0, 0);
            tick();
        end

        // T5: pause keeps prescaler phase
        ifa.mode = 1'b0; ifa.div = 8'd2; ifa.start = 1'b1;
        ex_a("t5_go", 28, 1, 0, 0);
        tick();
        ifa.start = 1'b0;
        ex_a("t5_pc1", 28, 1, 0, 0); tick();
        ex_a("t5_pc2", 28, 1, 0, 0); tick();
        ifa.en = 1'b0;
        for (int t = 0; t < 7; t++) begin
            ex_a($sformatf("t5_pause_%0d", t), 28, 1, 0, 0);
            tick();
        end
        ifa.en = 1'b1;
        ex_a("t5_resume", 0, 1, 1, 0); tick();
        ex_a("t5_r1", 0, 1, 0, 0); tick();
        ex_a("t5_r2", 0, 1, 0, 0); tick();
        ex_a("t5_r3", 1, 1, 0, 0); tick();
        ifa.stop = 1'b1;
        ex_a("t5_stop", 1, 0, 0, 0); tick();
        ifa.start = 1'b1;
        ex_a("t5_start_stop", 1, 0, 0, 0); tick();
        ifa.stop = 1'b0;
        ex_a("t5_restart", 1, 1, 0, 0); tick();
        ifa.start = 1'b0;
        ex_a("t5_s1", 1, 1, 0, 0); tick();
        ex_a("t5_s2", 1, 1, 0, 0); tick();
        ex_a("t5_s3", 2, 1, 0, 0); tick();

        // T6: reset mid-run at pos 15
        ifa.div = 8'd0;
        for (int t = 1; t <= 13; t++) begin
            ex_a($sformatf("t6_run_%0d", t), 2 + t, 1, 0, 0);
            tick();
        end
        rst = 1'b1;
        ex_a("t6_rst", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        ex_a("t6_after", 0, 0, 0, 0);
        tick();
        ifa.en = 1'b0;

        // Small instance: continuous forward, div=0
        ifb.en = 1'b1; ifb.start = 1'b1;
        ex_b("b2_go", 0, 1, 0, 0);
        tick();
        ifb.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            ex_b($sformatf("b2_%0d", i), i % 4, 1, (i % 4) == 0, 0);
            tick();
        end
        ifb.stop = 1'b1;
        ex_b("b2_stop", 0, 0, 0, 0);
        tick();
        ifb.stop = 1'b0;

        // Small instance: one-shot forward then reverse, div=1
        ifb.mode = 1'b1; ifb.div = 2'd1; ifb.start = 1'b1;
        ex_b("b4f_go", 0, 1, 0, 0);
        tick();
        ifb.start = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            ex_b($sformatf("b4f_%0d", t), t / 2, t < 6, 0, t == 6);
            tick();
        end
        ex_b("b4f_hold", 3, 0, 0, 0);
        tick();
        ifb.dir = 1'b1; ifb.start = 1'b1;
        ex_b("b4r_go", 3, 1, 0, 0);
        tick();
        ifb.start = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            ex_b($sformatf("b4r_%0d", t), 3 - t / 2, t < 6, 0, t == 6);
            tick();
        end

        // Small instance: mode switched to one-shot mid-run stops at end position
        ifb.dir = 1'b0; ifb.mode = 1'b0; ifb.div = 2'd0; ifb.start = 1'b1;
        ex_b("bm_go", 0, 1, 0, 0);
        tick();
        ifb.start = 1'b0;
        ex_b("bm_1", 1, 1, 0, 0); tick();
        ifb.mode = 1'b1;
        ex_b("bm_2", 2, 1, 0, 0); tick();
        ex_b("bm_3", 3, 0, 0, 1); tick();

        // Small instance: lowering div below pc forces the next advance
        ifb.mode = 1'b0; ifb.div = 2'd3; ifb.start = 1'b1;
        ex_b("bd_go", 3, 1, 0, 0);
        tick();
        ifb.start = 1'b0;
        ex_b("bd_pc1", 3, 1, 0, 0); tick();
        ex_b("bd_pc2", 3, 1, 0, 0); tick();
        ifb.div = 2'd0;
        ex_b("bd_adv", 0, 1, 1, 0); tick();
        ifb.stop = 1'b1;
        ex_b("bd_stop", 0, 0, 0, 0); tick();
        ifb.stop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
